dekatron_counter_line: RTL

Parametrised decimal counter line for the DekatronPC datapath: a chain of `DIGITS` one-hot decade counters that models dekatron stepping, with INC, DEC, LOAD and CLEAR operations behind a Request/Ready handshake. It generalises the fixed-width address, instruction-pointer and loop counters the CPU already uses, and adds four things to them:
- multi-step operations, repeated N unit steps per request;
- ripple carry at one digit per clock, as the tubes themselves behave;
- a selectable wrap or saturate mode;
- a sticky limit flag.

It is the building block for the next-generation IpLine, ApLine and loop counters.

---
 rtl/dekatron_pkg.sv | 30 +++
 rtl/dekatron_counter_line_digit.sv | 45 ++++
 rtl/dekatron_counter_line.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dekatron_pkg.sv
// Shared types and constants for the dekatron counter line and its digits.
package dekatron_pkg;

  localparam int DEKATRON_WIDTH = 10;

  localparam logic [DEKATRON_WIDTH-1:0] D0 = 10'b00_0000_0001;
  localparam logic [DEKATRON_WIDTH-1:0] D9 = 10'b10_0000_0000;

  typedef enum logic [1:0] {
    OP_INC   = 2'b00,
    OP_DEC   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_STEP = 2'b01,
    ST_DONE = 2'b10
  } line_state_t;

  // True when exactly one cathode is lit.
  function automatic logic is_one_hot(input logic [DEKATRON_WIDTH-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < DEKATRON_WIDTH; i++) ones += int'(v[i]);
    return ones == 1;
  endfunction

endpackage

// File: rtl/dekatron_counter_line_digit.sv
// One dekatron decade: one-hot ring register with clear, checked load and +/-1 rotate.
module dekatron_digit
  import dekatron_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      load_i,
  input  logic [DEKATRON_WIDTH-1:0] load_value_i,
  input  logic                      en_i,
  input  logic                      dec_i,
  output logic [DEKATRON_WIDTH-1:0] value_o,
  output logic                      wrap_o,
  output logic                      is_zero_o,
  output logic                      is_nine_o
);

  logic [DEKATRON_WIDTH-1:0] value_q, value_d;

  always_comb begin
    // NOTE: default first so every path assigns value_d; no latch is inferred.
    value_d = value_q;
    if (clear_i) begin
      value_d = D0;
    end else if (load_i) begin
      value_d = is_one_hot(load_value_i) ? load_value_i : D0;
    end else if (en_i) begin
      value_d = dec_i ? {value_q[0], value_q[DEKATRON_WIDTH-1:1]}
                      : {value_q[DEKATRON_WIDTH-2:0], value_q[DEKATRON_WIDTH-1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) value_q <= D0;
    else     value_q <= value_d;
  end

  assign value_o   = value_q;
  assign is_zero_o = (value_q == D0);
  assign is_nine_o = (value_q == D9);
  // Carry/borrow that a step in the current direction would produce.
  assign wrap_o    = dec_i ? is_zero_o : is_nine_o;

endmodule

// File: rtl/dekatron_counter_line.sv
// Chain of DIGITS dekatron decades with ripple carry one digit per clock and a
// Request/Ready handshake for INC/DEC (repeated), LOAD and CLEAR.
module dekatron_counter_line
  import dekatron_pkg::*;
#(
  parameter int DIGITS     = 6,
  parameter int STEP_WIDTH = 4
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             Request,
  input  logic [1:0]                       Op,
  input  logic [STEP_WIDTH-1:0]            Steps,
  input  logic                             Saturate,
  input  logic [DIGITS*DEKATRON_WIDTH-1:0] LoadValue,
  output logic                             Ready,
  output logic [DIGITS*DEKATRON_WIDTH-1:0] Count,
  output logic                             Zero,
  output logic                             Limit
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int LW = DIGITS * DEKATRON_WIDTH;
  localparam logic [KW-1:0]         K_TOP    = KW'(DIGITS - 1);
  localparam logic [KW-1:0]         K_ONE    = KW'(1);
  localparam logic [STEP_WIDTH-1:0] STEP_ONE = STEP_WIDTH'(1);

  line_state_t           state_q, state_d;
  op_t                   op_q, op_d;
  logic                  sat_q, sat_d;
  logic [STEP_WIDTH-1:0] remaining_q, remaining_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  limit_q, limit_d;
  logic [LW-1:0]         load_q, load_d;

  logic [DIGITS-1:0] digit_en;
  logic [DIGITS-1:0] digit_wrap;
  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] digit_nine;
  logic              load_all;
  logic              clear_all;
  logic              is_dec;
  logic              at_limit;
  logic              accept;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    dekatron_digit u_digit (
      .clk          (Clk),
      .rst          (Rst),
      .clear_i      (clear_all),
      .load_i       (load_all),
      .load_value_i (load_q[i*DEKATRON_WIDTH +: DEKATRON_WIDTH]),
      .en_i         (digit_en[i]),
      .dec_i        (is_dec),
      .value_o      (Count[i*DEKATRON_WIDTH +: DEKATRON_WIDTH]),
      .wrap_o       (digit_wrap[i]),
      .is_zero_o    (digit_zero[i]),
      .is_nine_o    (digit_nine[i])
    );
  end

  assign is_dec   = (op_q == OP_DEC);
  assign at_limit = is_dec ? (&digit_zero) : (&digit_nine);
  assign Ready    = (state_q != ST_STEP);
  assign accept   = Request && Ready;
  assign Zero     = &digit_zero;
  assign Limit    = limit_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sat_d       = sat_q;
    remaining_d = remaining_q;
    k_d         = k_q;
    limit_d     = limit_q;
    load_d      = load_q;
    digit_en    = '0;
    load_all    = 1'b0;
    clear_all   = 1'b0;

    if (accept) begin
      op_d        = op_t'(Op);
      sat_d       = Saturate;
      remaining_d = Steps;
      load_d      = LoadValue;
      k_d         = '0;
      limit_d     = 1'b0;
      state_d     = ST_STEP;
    end else begin
      case (state_q)
        ST_DONE: state_d = ST_IDLE;
        ST_STEP: begin
          case (op_q)
            OP_LOAD: begin
              load_all = 1'b1;
              state_d  = ST_DONE;
            end
            OP_CLEAR: begin
              clear_all = 1'b1;
              state_d   = ST_DONE;
            end
            default: begin
              if (remaining_q == '0) begin
                state_d = ST_DONE;
              end else if ((k_q == '0) && sat_q && at_limit) begin
                // Saturation check spends one edge without touching the digits.
                limit_d = 1'b1;
                state_d = ST_DONE;
              end else begin
                digit_en[k_q] = 1'b1;
                if (digit_wrap[k_q] && (k_q != K_TOP)) begin
                  k_d = k_q + K_ONE;
                end else begin
                  if (digit_wrap[k_q]) limit_d = 1'b1;
                  remaining_d = remaining_q - STEP_ONE;
                  k_d         = '0;
                  if (remaining_q == STEP_ONE) state_d = ST_DONE;
                end
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_INC;
      sat_q       <= 1'b0;
      remaining_q <= '0;
      k_q         <= '0;
      limit_q     <= 1'b0;
      load_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sat_q       <= sat_d;
      remaining_q <= remaining_d;
      k_q         <= k_d;
      limit_q     <= limit_d;
      load_q      <= load_d;
    end
  end

endmodule
